// File: rtl/sram_mem_access_if.sv
`default_nettype none
// ============================================================================
//  Module   : sram_mem_access_if
//  Purpose  : Request/response and SRAM pin bundle for the memory-access stage.
//  Revision : 1.0  initial release
// ============================================================================
interface sram_mem_access_if #(
    parameter int ADDR_W = 11
);
    logic              req_valid;
    logic              req_we;
    logic [31:0]       base;
    logic [15:0]       offset;
    logic [31:0]       wdata;
    logic              req_ready;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rdata;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_dout;
    logic [31:0]       sram_din;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    // Master plays both the requesting pipeline and the SRAM device.
    modport master (
        output req_valid, req_we, base, offset, wdata, sram_din,
        input  req_ready, rsp_valid, rsp_err, rdata,
               sram_addr, sram_dout, sram_ce_n, sram_oe_n, sram_we_n
    );

    modport slave (
        input  req_valid, req_we, base, offset, wdata, sram_din,
        output req_ready, rsp_valid, rsp_err, rdata,
               sram_addr, sram_dout, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface
`default_nettype wire

// File: rtl/sram_mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : sram_mem_access
//  Purpose  : MIPS lw/sw stage driving an async SRAM via setup/strobe/done.
//             Optional misalignment rejection: define MEM_ALIGN_CHECK_EN.
//  Revision : 1.0  initial release
// ============================================================================
module sram_mem_access #(
    parameter int ADDR_W      = 11,
    parameter int WAIT_CYCLES = 1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    sram_mem_access_if.slave     bus
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [3:0] c_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            r_state;
    logic [3:0]        r_cnt;
    logic              r_we;
    logic              r_ready;
    logic              r_rspValid;
    logic [31:0]       r_rdata;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_dout;
    logic              r_ceN;
    logic              r_oeN;
    logic              r_weN;
`ifdef MEM_ALIGN_CHECK_EN
    logic              r_rspErr;
`endif

    logic [31:0] w_ea;
    logic        w_accept;
    wire         w_unused = &{1'b0, w_ea[31:ADDR_W+2], w_ea[1:0]};

    assign w_ea     = bus.base + {{16{bus.offset[15]}}, bus.offset};
    assign w_accept = bus.req_valid && r_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_ready    <= 1'b1;
            r_rspValid <= 1'b0;
            r_rdata    <= 32'd0;
            r_addr     <= '0;
            r_dout     <= 32'd0;
            r_ceN      <= 1'b1;
            r_oeN      <= 1'b1;
            r_weN      <= 1'b1;
`ifdef MEM_ALIGN_CHECK_EN
            r_rspErr   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
`ifdef MEM_ALIGN_CHECK_EN
                        // Misaligned: skip the SRAM entirely, reuse DONE as the error cycle.
                        if (w_ea[1:0] != 2'b00) begin
                            r_state  <= S_DONE;
                            r_ready  <= 1'b0;
                            r_rspErr <= 1'b1;
                        end else begin
`endif
                            r_state <= S_SETUP;
                            r_ready <= 1'b0;
                            r_we    <= bus.req_we;
                            r_addr  <= w_ea[ADDR_W+1:2];
                            r_dout  <= bus.wdata;
                            r_ceN   <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                        end
`endif
                    end
                end
                S_SETUP: begin
                    r_state <= S_STROBE;
                    r_cnt   <= c_WAIT_LOAD;
                    if (r_we) begin
                        r_weN <= 1'b0;
                    end else begin
                        r_oeN <= 1'b0;
                    end
                end
                S_STROBE: begin
                    if (r_cnt == 4'd0) begin
                        r_state    <= S_DONE;
                        r_ceN      <= 1'b1;
                        r_oeN      <= 1'b1;
                        r_weN      <= 1'b1;
                        r_rspValid <= 1'b1;
                        if (!r_we) begin
                            r_rdata <= bus.sram_din;
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_ready    <= 1'b1;
                    r_rspValid <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
                    r_rspErr   <= 1'b0;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.rsp_valid = r_rspValid;
`ifdef MEM_ALIGN_CHECK_EN
    assign bus.rsp_err   = r_rspErr;
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign bus.rdata     = r_rdata;
    assign bus.sram_addr = r_addr;
    assign bus.sram_dout = r_dout;
    assign bus.sram_ce_n = r_ceN;
    assign bus.sram_oe_n = r_oeN;
    assign bus.sram_we_n = r_weN;
endmodule
`default_nettype wire

// File: tb/tb_sram_mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_mem_access
//  Purpose  : Directed checks of sram_mem_access at WAIT_CYCLES = 1, 3 and 4.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sram_mem_access;
    logic clk = 1'b0;
    logic reset;
    int   nCmp = 0;
    int   nErr = 0;

    always #5 clk = ~clk;

    sram_mem_access_if #(.ADDR_W(11)) b0 ();
    sram_mem_access_if #(.ADDR_W(11)) b1 ();
    sram_mem_access_if #(.ADDR_W(11)) b2 ();

    sram_mem_access #(.ADDR_W(11), .WAIT_CYCLES(1)) u0 (.clk(clk), .reset(reset), .bus(b0.slave));
    sram_mem_access #(.ADDR_W(11), .WAIT_CYCLES(3)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
    sram_mem_access #(.ADDR_W(11), .WAIT_CYCLES(4)) u2 (.clk(clk), .reset(reset), .bus(b2.slave));

    // SRAM models: unwritten words read back as a per-instance pattern.
    bit [31:0] mem0 [2048];
    bit [31:0] mem1 [2048];
    bit [31:0] mem2 [2048];
    bit        wr0  [2048];
    bit        wr1  [2048];
    bit        wr2  [2048];

    always @(posedge clk) begin
        if (!b0.sram_ce_n && !b0.sram_we_n) begin mem0[b0.sram_addr] <= b0.sram_dout; wr0[b0.sram_addr] <= 1'b1; end
        if (!b1.sram_ce_n && !b1.sram_we_n) begin mem1[b1.sram_addr] <= b1.sram_dout; wr1[b1.sram_addr] <= 1'b1; end
        if (!b2.sram_ce_n && !b2.sram_we_n) begin mem2[b2.sram_addr] <= b2.sram_dout; wr2[b2.sram_addr] <= 1'b1; end
    end

    assign b0.sram_din = wr0[b0.sram_addr] ? mem0[b0.sram_addr] : (32'hA000_0000 | 32'(b0.sram_addr));
    assign b1.sram_din = wr1[b1.sram_addr] ? mem1[b1.sram_addr] : (32'hB000_0000 | 32'(b1.sram_addr));
    assign b2.sram_din = wr2[b2.sram_addr] ? mem2[b2.sram_addr] : (32'hC000_0000 | 32'(b2.sram_addr));

    // {req_ready, rsp_valid, rsp_err, ce_n, oe_n, we_n}
    logic [5:0] st0, st1, st2;
    assign st0 = {b0.req_ready, b0.rsp_valid, b0.rsp_err, b0.sram_ce_n, b0.sram_oe_n, b0.sram_we_n};
    assign st1 = {b1.req_ready, b1.rsp_valid, b1.rsp_err, b1.sram_ce_n, b1.sram_oe_n, b1.sram_we_n};
    assign st2 = {b2.req_ready, b2.rsp_valid, b2.rsp_err, b2.sram_ce_n, b2.sram_oe_n, b2.sram_we_n};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        assert (got === exp) else begin
            nErr++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full W=1 transaction on instance 0, checked cycle by cycle.
    task automatic run0(input string tag, input logic we, input logic [31:0] b, input logic [15:0] o,
                        input logic [31:0] d, input logic [10:0] expAddr, input logic [31:0] expRdata);
        b0.req_valid = 1'b1; b0.req_we = we; b0.base = b; b0.offset = o; b0.wdata = d;
        tick();
        b0.req_valid = 1'b0;
        chk({tag, " c1 addr"}, 32'(b0.sram_addr), 32'(expAddr));
        chk({tag, " c1 status"}, 32'(st0), 32'(6'b000011));
        tick();
        chk({tag, " c2 status"}, 32'(st0), we ? 32'(6'b000010) : 32'(6'b000001));
        tick();
        chk({tag, " c3 status"}, 32'(st0), 32'(6'b010111));
        chk({tag, " c3 rdata"}, b0.rdata, expRdata);
        tick();
        chk({tag, " c4 status"}, 32'(st0), 32'(6'b100111));
    endtask

    initial begin
        reset = 1'b1;
        b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.base = '0; b0.offset = '0; b0.wdata = '0;
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.base = '0; b1.offset = '0; b1.wdata = '0;
        b2.req_valid = 1'b0; b2.req_we = 1'b0; b2.base = '0; b2.offset = '0; b2.wdata = '0;
        tick();
        tick();
        chk("reset status", 32'(st0), 32'(6'b100111));
        chk("reset rdata", b0.rdata, 32'd0);
        chk("reset addr", 32'(b0.sram_addr), 32'd0);
        chk("reset dout", b0.sram_dout, 32'd0);
        reset = 1'b0;
        tick();

        // Store, load back, sign-extended negative offset, address wrap.
        run0("sw",    1'b1, 32'h10, 16'h0004, 32'hDEADBEEF, 11'd5,     32'd0);
        chk("sw dout hold", b0.sram_dout, 32'hDEADBEEF);
        run0("lw",    1'b0, 32'h10, 16'h0004, 32'h0,        11'd5,     32'hDEADBEEF);
        run0("neg",   1'b0, 32'h20, 16'hFFF8, 32'h0,        11'd6,     32'hA000_0006);
        run0("wrap",  1'b0, 32'h00, 16'hFFFC, 32'h0,        11'h7FF,   32'hA000_07FF);
        chk("idle addr hold", 32'(b0.sram_addr), 32'h7FF);

`ifdef MEM_ALIGN_CHECK_EN
        b0.req_valid = 1'b1; b0.req_we = 1'b0; b0.base = 32'h10; b0.offset = 16'h0002;
        tick();
        b0.req_valid = 1'b0;
        chk("misalign c1 status", 32'(st0), 32'(6'b001111));
        tick();
        chk("misalign c2 status", 32'(st0), 32'(6'b100111));
        chk("misalign rdata", b0.rdata, 32'hA000_07FF);
`else
        run0("misalign", 1'b0, 32'h10, 16'h0002, 32'h0, 11'd4, 32'hA000_0004);
`endif

        // Back-to-back stores on W=3 with req_valid held high.
        b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.base = 32'h40; b1.offset = 16'h0; b1.wdata = 32'h1111_1111;
        tick();
        b1.base = 32'h44; b1.wdata = 32'h2222_2222;
        chk("b2b c1 addr", 32'(b1.sram_addr), 32'h10);
        for (int c = 1; c <= 7; c++) begin
            logic [5:0] e;
            if (c == 1 || c == 7)  e = 6'b000011;
            else if (c <= 4)       e = 6'b000010;
            else if (c == 5)       e = 6'b010111;
            else                   e = 6'b100111;
            chk($sformatf("b2b c%0d status", c), 32'(st1), 32'(e));
            if (c < 7) tick();
        end
        b1.req_valid = 1'b0;
        chk("b2b c7 addr", 32'(b1.sram_addr), 32'h11);
        chk("b2b c7 dout", b1.sram_dout, 32'h2222_2222);
        repeat (5) tick();
        chk("b2b second done", 32'(st1), 32'(6'b100111));
        b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.base = 32'h40;
        tick();
        b1.req_valid = 1'b0;
        repeat (4) tick();
        chk("b2b readback status", 32'(st1), 32'(6'b010111));
        chk("b2b readback rdata", b1.rdata, 32'h1111_1111);
        tick();

        // Reset in the middle of a W=4 strobe.
        b2.req_valid = 1'b1; b2.req_we = 1'b0; b2.base = 32'h100; b2.offset = 16'h0;
        tick();
        b2.req_valid = 1'b0;
        tick();
        chk("rst c2 status", 32'(st2), 32'(6'b000001));
        tick();
        chk("rst c3 status", 32'(st2), 32'(6'b000001));
        #2 reset = 1'b1;
        #1;
        chk("rst async status", 32'(st2), 32'(6'b100111));
        chk("rst async addr", 32'(b2.sram_addr), 32'd0);
        tick();
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("rst quiet %0d", c), 32'(st2), 32'(6'b100111));
            tick();
        end
        chk("rst rdata", b2.rdata, 32'd0);
        b2.req_valid = 1'b1; b2.base = 32'h100; b2.offset = 16'h0008;
        tick();
        b2.req_valid = 1'b0;
        chk("post-rst c1 addr", 32'(b2.sram_addr), 32'h42);
        repeat (5) tick();
        chk("post-rst c6 status", 32'(st2), 32'(6'b010111));
        chk("post-rst rdata", b2.rdata, 32'hC000_0042);
        tick();
        chk("post-rst c7 status", 32'(st2), 32'(6'b100111));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/sram_mem_access.md
# sram_mem_access

Memory-access stage of the single-cycle/multicycle MIPS datapath: takes one load-word or store-word request per transaction, computes the effective address `$s + sign_extend(offset)`, and runs the off-chip asynchronous SRAM through a setup/strobe/done sequence. It sits directly downstream of the register-read/decode logic that services `lw $t, offset($s)` and `sw $t, offset($s)`. It returns load data to the register-file write-back path and stalls the PC-advance logic through `req_ready` until the access completes.

## Interface
- `ADDR_W`, default 11: SRAM word-address width. The SRAM holds `2**ADDR_W` 32-bit words.
- `WAIT_CYCLES`, default 1: number of cycles the strobe is held active. Legal range is 1..15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_we`  in  1  1 = store word (sw), 0 = load word (lw).
- `base`  in  32  contents of `$s`.
- `offset`  in  16  signed immediate.
- `wdata`  in  32  contents of `$t` for a store.
- `req_ready`  out  1  stage idle and able to accept a request.
- `rsp_valid`  out  1  one-cycle completion pulse, for both loads and stores.
- `rsp_err`  out  1  one-cycle pulse marking a rejected misaligned request.
- `rdata`  out  32  load result.
- `sram_addr`  out  ADDR_W  word address to the SRAM.
- `sram_dout`  out  32  write data to the SRAM.
- `sram_din`  in  32  read data from the SRAM.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low SRAM strobes.

## Operation
- **Effective address:** `ea = base + {{16{offset[15]}}, offset}`, computed mod 2^32. `sram_addr = ea[ADDR_W+1:2]`. Upper bits are dropped, so out-of-range addresses wrap.
- **Acceptance:** a request is accepted on a rising edge where `req_valid && req_ready`. At that edge, `ea`, `req_we` and `wdata` are registered. Inputs are ignored at all other times.
- **State machine:**
  - IDLE → SETUP on acceptance.
  - SETUP → STROBE, always.
  - STROBE holds for `WAIT_CYCLES` cycles, counted by a 4-bit down-counter, then moves to DONE.
  - DONE → IDLE, always.
- **Output decode (registered):**
  - IDLE: `req_ready`=1; all strobes high.
  - SETUP: `sram_ce_n`=0; address and data stable; `oe_n`/`we_n` high.
  - STROBE: `ce_n`=0; `we_n`=0 for a store, `oe_n`=0 for a load.
  - DONE: all strobes high; `rsp_valid`=1.
- **Load capture:** `rdata` takes `sram_din` on the edge that leaves STROBE. It holds that value until the next load completes; stores do not modify it.
- `sram_addr` and `sram_dout` hold their last values while IDLE.
- **Reset values:**
  - State = IDLE, `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rdata`=0.
  - `sram_addr`=0, `sram_dout`=0.
  - All strobes = 1.
- **Reset during an access:** the strobes deassert immediately (asynchronous), the transaction is abandoned, and no `rsp_valid` is produced.

## Timing
- **Latency:** for an acceptance edge E0, SETUP occupies cycle 1, STROBE occupies cycles 2..1+W, and DONE (`rsp_valid`=1) is cycle 2+W. `req_ready` returns to 1 in cycle 3+W.
- **Throughput:** one access per 3+W cycles. With `req_valid` held high, the next request is accepted on the first edge of cycle 3+W.
- **Store timing:** address and data are stable for one full cycle before `we_n` falls and remain stable through the cycle after it rises. This meets SRAM address-setup and data-hold requirements.
- `rsp_valid` and `rsp_err` are never asserted in the same cycle.

## Configuration
- **`MEM_ALIGN_CHECK_EN` defined:**
  - An accepted request with `ea[1:0] != 0` performs no SRAM access.
  - The FSM goes IDLE → DONE-equivalent error cycle → IDLE. `rsp_err` pulses in cycle 1 and `req_ready` is 1 again in cycle 2.
  - `rdata` and SRAM contents are unchanged.
- **`MEM_ALIGN_CHECK_EN` not defined:** `ea[1:0]` is ignored and the access proceeds to the word at `ea[ADDR_W+1:2]`. `rsp_err` is tied to 0.

## Test plan
- **Store, WAIT_CYCLES=1:** sw with base=0x10, offset=4, wdata=0xDEADBEEF → `sram_addr`=5, `we_n` low exactly in cycle 2, `rsp_valid` in cycle 3, `req_ready`=1 in cycle 4.
- **Load back:** lw of the same address (SRAM model returns 0xDEADBEEF) → `rdata`=0xDEADBEEF in cycle 3 with `rsp_valid`; `oe_n` low only in cycle 2.
- **Negative offset:** lw with base=0x20, offset=0xFFF8 (-8) → `sram_addr`=6. Also base=0x0, offset=-4 → `sram_addr`=0x7FF (wrap).
- **Back-to-back:** `req_valid` held high for two stores with W=3 → second acceptance exactly 6 cycles after the first; no strobe overlap.
- **Misaligned, macro defined:** lw at ea=0x12 → `rsp_err` pulses in cycle 1, `ce_n` never falls, `rdata` unchanged. Without the macro, the same request reads word 4.
- **Reset mid-STROBE (W=4):** assert `reset` in cycle 3 → strobes go high the same cycle, no `rsp_valid`, all outputs at reset values. After release, a new lw completes normally.
